// File: rtl/dma_csr_bank.sv
// rtl/dma_csr_bank.sv - multi-channel MMIO CSR bank for CCI-P copy engines
// Serves the AFU header, per-channel descriptors, start pulses and completion status.

module dma_csr_bank #(
   parameter int           NUM_CH = 4,
   parameter int           SIZE_W = 32,
   parameter logic [127:0] AFU_ID = 128'h0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       mmio_wr_valid,
   input  logic                       mmio_rd_valid,
   input  logic [15:0]                mmio_addr,
   input  logic [8:0]                 mmio_tid,
   input  logic [63:0]                mmio_wdata,
   output logic                       rd_valid,
   output logic [8:0]                 rd_tid,
   output logic [63:0]                rd_data,
   output logic [NUM_CH*42-1:0]       ch_src_addr,
   output logic [NUM_CH*42-1:0]       ch_dst_addr,
   output logic [NUM_CH*SIZE_W-1:0]   ch_size_cl,
   output logic [NUM_CH-1:0]          ch_start,
   input  logic [NUM_CH-1:0]          ch_done
);

   localparam logic [63:0] DFH = {4'b0001, 8'b0, 4'b0, 7'b0, 1'b1, 24'b0, 4'b0, 12'b0};

   logic [41:0]       srcReg   [NUM_CH];
   logic [41:0]       dstReg   [NUM_CH];
   logic [SIZE_W-1:0] sizeReg  [NUM_CH];
   logic [31:0]       countReg [NUM_CH];
   logic [NUM_CH-1:0] busy, done, err, startReg;
   logic [63:0]       scratch;

   logic [NUM_CH-1:0] chHit, wrSrc, wrDst, wrSize, wrCtrl, busyAfterDone;
   logic [NUM_CH-1:0] nBusy, nDone, nErr, nStart;
   logic [31:0]       nCount [NUM_CH];
   logic [63:0]       rdMux;

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         chHit[c]  = (mmio_addr[15:4] == 12'(c + 2));
         wrSrc[c]  = mmio_wr_valid && chHit[c] && (mmio_addr[3:0] == 4'h0);
         wrDst[c]  = mmio_wr_valid && chHit[c] && (mmio_addr[3:0] == 4'h2);
         wrSize[c] = mmio_wr_valid && chHit[c] && (mmio_addr[3:0] == 4'h4);
         wrCtrl[c] = mmio_wr_valid && chHit[c] && (mmio_addr[3:0] == 4'h6);
      end
   end

   // An engine completion is folded in before any CTRL/descriptor write of the same cycle.
   assign busyAfterDone = busy & ~ch_done;

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         nBusy[c]  = busyAfterDone[c];
         nDone[c]  = done[c];
         nErr[c]   = err[c];
         nStart[c] = 1'b0;
         nCount[c] = countReg[c];
         if (ch_done[c] && busy[c]) begin
            nDone[c]  = 1'b1;
            nCount[c] = nCount[c] + 32'd1;
         end
         if ((wrSrc[c] || wrDst[c] || wrSize[c]) && busyAfterDone[c])
            nErr[c] = 1'b1;
         if (wrCtrl[c] && mmio_wdata[1]) begin
            nDone[c] = 1'b0;
            nErr[c]  = 1'b0;
         end
         if (wrCtrl[c] && mmio_wdata[0]) begin
            if (busyAfterDone[c]) begin
               nErr[c] = 1'b1;
            end else if (sizeReg[c] != '0) begin
               nBusy[c]  = 1'b1;
               nStart[c] = 1'b1;
            end else begin
               nDone[c]  = 1'b1;
               nCount[c] = nCount[c] + 32'd1;
            end
         end
      end
   end

   always_comb begin
      rdMux = '0;
      if (!mmio_addr[0]) begin
         case (mmio_addr)
            16'h0000: rdMux = DFH;
            16'h0002: rdMux = AFU_ID[63:0];
            16'h0004: rdMux = AFU_ID[127:64];
            16'h0010: rdMux = 64'(NUM_CH);
            16'h0012: rdMux = scratch;
            default:  rdMux = '0;
         endcase
         for (int c = 0; c < NUM_CH; c++) begin
            if (chHit[c]) begin
               case (mmio_addr[3:0])
                  4'h0:    rdMux = {22'b0, srcReg[c]};
                  4'h2:    rdMux = {22'b0, dstReg[c]};
                  4'h4:    rdMux = 64'({sizeReg[c], 6'b0});
                  4'h8:    rdMux = {countReg[c], 29'b0, err[c], done[c], busy[c]};
                  default: rdMux = '0;
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_valid <= 1'b0;
         rd_tid   <= '0;
         rd_data  <= '0;
         scratch  <= '0;
         busy     <= '0;
         done     <= '0;
         err      <= '0;
         startReg <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            srcReg[c]   <= '0;
            dstReg[c]   <= '0;
            sizeReg[c]  <= '0;
            countReg[c] <= '0;
         end
      end else begin
         rd_valid <= mmio_rd_valid;
         rd_data  <= mmio_rd_valid ? rdMux : 64'h0;
         if (mmio_rd_valid)
            rd_tid <= mmio_tid;
         if (mmio_wr_valid && (mmio_addr == 16'h0012))
            scratch <= mmio_wdata;
         busy     <= nBusy;
         done     <= nDone;
         err      <= nErr;
         startReg <= nStart;
         for (int c = 0; c < NUM_CH; c++) begin
            countReg[c] <= nCount[c];
            if (wrSrc[c] && !busyAfterDone[c])
               srcReg[c] <= mmio_wdata[41:0];
            if (wrDst[c] && !busyAfterDone[c])
               dstReg[c] <= mmio_wdata[41:0];
            if (wrSize[c] && !busyAfterDone[c])
               sizeReg[c] <= mmio_wdata[SIZE_W+5:6];
         end
      end
   end

   assign ch_start = startReg;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
      assign ch_src_addr[42*g +: 42]       = srcReg[g];
      assign ch_dst_addr[42*g +: 42]       = dstReg[g];
      assign ch_size_cl[SIZE_W*g +: SIZE_W] = sizeReg[g];
   end

endmodule

// File: tb/tb_dma_csr_bank.sv
// tb/tb_dma_csr_bank.sv - self-checking bench for dma_csr_bank
// Directed scenarios plus randomized MMIO traffic against a register-map reference model.

module tb_dma_csr_bank;

   localparam int           NCH  = 4;
   localparam logic [127:0] UUID = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

   logic              clk = 1'b0;
   logic              reset;
   logic              mmio_wr_valid, mmio_rd_valid;
   logic [15:0]       mmio_addr;
   logic [8:0]        mmio_tid;
   logic [63:0]       mmio_wdata;
   logic              rd_valid;
   logic [8:0]        rd_tid;
   logic [63:0]       rd_data;
   logic [NCH*42-1:0] ch_src_addr, ch_dst_addr;
   logic [NCH*32-1:0] ch_size_cl;
   logic [NCH-1:0]    ch_start, ch_done;

   int nTests = 0;
   int nFail  = 0;

   logic [41:0] mSrc [NCH];
   logic [41:0] mDst [NCH];
   logic [31:0] mSize [NCH];
   logic [31:0] mCount [NCH];
   bit          mBusy [NCH];
   bit          mDone [NCH];
   bit          mErr [NCH];
   logic [63:0] mScratch;

   logic [63:0]    expRd;
   logic [8:0]     expTid;
   logic           expValid;
   logic [NCH-1:0] expStart;

   dma_csr_bank #(.NUM_CH(NCH), .SIZE_W(32), .AFU_ID(UUID)) dut (
      .clk(clk), .reset(reset),
      .mmio_wr_valid(mmio_wr_valid), .mmio_rd_valid(mmio_rd_valid),
      .mmio_addr(mmio_addr), .mmio_tid(mmio_tid), .mmio_wdata(mmio_wdata),
      .rd_valid(rd_valid), .rd_tid(rd_tid), .rd_data(rd_data),
      .ch_src_addr(ch_src_addr), .ch_dst_addr(ch_dst_addr), .ch_size_cl(ch_size_cl),
      .ch_start(ch_start), .ch_done(ch_done)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic mReset();
      for (int i = 0; i < NCH; i++) begin
         mSrc[i] = '0; mDst[i] = '0; mSize[i] = '0; mCount[i] = '0;
         mBusy[i] = 0; mDone[i] = 0; mErr[i] = 0;
      end
      mScratch = '0;
   endtask

   function automatic logic [63:0] mRead(input logic [15:0] a);
      int c, off;
      if (a[0]) return 64'h0;
      if (a == 16'h0000) return 64'h1000_0100_0000_0000;
      if (a == 16'h0002) return UUID[63:0];
      if (a == 16'h0004) return UUID[127:64];
      if (a == 16'h0010) return 64'(NCH);
      if (a == 16'h0012) return mScratch;
      if (int'(a) >= 32 && int'(a) < 32 + 16 * NCH) begin
         c   = (int'(a) - 32) / 16;
         off = (int'(a) - 32) % 16;
         case (off)
            0: return 64'(mSrc[c]);
            2: return 64'(mDst[c]);
            4: return 64'(mSize[c]) * 64;
            8: return (64'(mCount[c]) << 32) + 64'(mErr[c]) * 4 + 64'(mDone[c]) * 2 + 64'(mBusy[c]);
            default: return 64'h0;
         endcase
      end
      return 64'h0;
   endfunction

   task automatic mApply(input logic wr, input logic [15:0] a, input logic [63:0] wd,
                         input logic [NCH-1:0] dn, output logic [NCH-1:0] st);
      int c, off;
      st = '0;
      for (int i = 0; i < NCH; i++)
         if (dn[i] && mBusy[i]) begin
            mBusy[i] = 0; mDone[i] = 1; mCount[i] = mCount[i] + 1;
         end
      if (!wr) return;
      if (a == 16'h0012) mScratch = wd;
      if (int'(a) >= 32 && int'(a) < 32 + 16 * NCH) begin
         c   = (int'(a) - 32) / 16;
         off = (int'(a) - 32) % 16;
         case (off)
            0: if (mBusy[c]) mErr[c] = 1; else mSrc[c] = wd[41:0];
            2: if (mBusy[c]) mErr[c] = 1; else mDst[c] = wd[41:0];
            4: if (mBusy[c]) mErr[c] = 1; else mSize[c] = 32'(wd / 64);
            6: begin
               if (wd[1]) begin mDone[c] = 0; mErr[c] = 0; end
               if (wd[0]) begin
                  if (mBusy[c]) mErr[c] = 1;
                  else if (mSize[c] != 0) begin mBusy[c] = 1; st[c] = 1'b1; end
                  else begin mDone[c] = 1; mCount[c] = mCount[c] + 1; end
               end
            end
            default: ;
         endcase
      end
   endtask

   // One bus cycle: drive at a falling edge, return at the next falling edge with outputs settled.
   task automatic op(input logic wr, input logic rd, input logic [15:0] a, input logic [8:0] tid,
                     input logic [63:0] wd, input logic [NCH-1:0] dn);
      expRd    = mRead(a);
      expValid = rd;
      expTid   = tid;
      mApply(wr, a, wd, dn, expStart);
      mmio_wr_valid = wr; mmio_rd_valid = rd; mmio_addr = a;
      mmio_tid = tid; mmio_wdata = wd; ch_done = dn;
      @(negedge clk);
      mmio_wr_valid = 1'b0; mmio_rd_valid = 1'b0; ch_done = '0;
   endtask

   task automatic doWrite(input logic [15:0] a, input logic [63:0] wd);
      op(1'b1, 1'b0, a, 9'h0, wd, '0);
   endtask

   task automatic doRead(input logic [15:0] a, input logic [8:0] tid);
      op(1'b0, 1'b1, a, tid, 64'h0, '0);
   endtask

   task automatic test_reset();
      nTests++;
      if (rd_valid !== 1'b0 || rd_tid !== 9'h0 || rd_data !== 64'h0) begin
         nFail++; $display("FAIL reset_rd got v=%b tid=%h d=%h exp 0", rd_valid, rd_tid, rd_data);
      end
      nTests++;
      if (ch_start !== '0 || ch_src_addr !== '0 || ch_dst_addr !== '0 || ch_size_cl !== '0) begin
         nFail++; $display("FAIL reset_ch got start=%b size=%h exp 0", ch_start, ch_size_cl);
      end
      reset = 1'b0;
      mReset();
      @(negedge clk);
   endtask

   task automatic test_header();
      logic [15:0] addrs [4];
      logic [63:0] exps [4];
      addrs = '{16'h0000, 16'h0002, 16'h0004, 16'h0010};
      exps  = '{64'h1000_0100_0000_0000, UUID[63:0], UUID[127:64], 64'd4};
      for (int i = 0; i < 4; i++) begin
         doRead(addrs[i], 9'h1A);
         nTests++;
         if (rd_valid !== 1'b1 || rd_tid !== 9'h1A || rd_data !== exps[i]) begin
            nFail++; $display("FAIL header[%0d] got v=%b tid=%h d=%h exp v=1 tid=1a d=%h",
                              i, rd_valid, rd_tid, rd_data, exps[i]);
         end
      end
      op(1'b0, 1'b0, 16'h0, 9'h0, 64'h0, '0);
      nTests++;
      if (rd_valid !== 1'b0) begin nFail++; $display("FAIL header_idle got rd_valid=%b exp 0", rd_valid); end
   endtask

   task automatic test_ch1();
      doWrite(16'h0030, 64'h100);
      doWrite(16'h0032, 64'h200);
      doWrite(16'h0034, 64'd4096);
      nTests++;
      if (ch_size_cl[63:32] !== 32'd64 || ch_src_addr[83:42] !== 42'h100 || ch_dst_addr[83:42] !== 42'h200) begin
         nFail++; $display("FAIL ch1_desc got size=%h src=%h dst=%h exp 40/100/200",
                           ch_size_cl[63:32], ch_src_addr[83:42], ch_dst_addr[83:42]);
      end
      doWrite(16'h0036, 64'h1);
      nTests++;
      if (ch_start !== 4'b0010) begin nFail++; $display("FAIL ch1_start got %b exp 0010", ch_start); end
      doRead(16'h0038, 9'h05);
      nTests++;
      if (ch_start !== 4'b0000) begin nFail++; $display("FAIL ch1_pulse_width got %b exp 0000", ch_start); end
      nTests++;
      if (rd_data !== 64'h1) begin nFail++; $display("FAIL ch1_busy got %h exp 1", rd_data); end
      op(1'b0, 1'b0, 16'h0, 9'h0, 64'h0, 4'b0010);
      doRead(16'h0038, 9'h06);
      nTests++;
      if (rd_data !== 64'h1_0000_0002) begin nFail++; $display("FAIL ch1_done got %h exp 100000002", rd_data); end
   endtask

   task automatic test_busy_err();
      doWrite(16'h0024, 64'd128);
      doWrite(16'h0026, 64'h1);
      doWrite(16'h0020, 64'hABC);
      doWrite(16'h0026, 64'h1);
      nTests++;
      if (ch_start !== 4'b0000 || ch_src_addr[41:0] !== 42'h0) begin
         nFail++; $display("FAIL busy_drop got start=%b src=%h exp 0/0", ch_start, ch_src_addr[41:0]);
      end
      doRead(16'h0028, 9'h07);
      nTests++;
      if (rd_data !== 64'h5) begin nFail++; $display("FAIL busy_err got %h exp 5", rd_data); end
      doWrite(16'h0026, 64'h2);
      doRead(16'h0028, 9'h08);
      nTests++;
      if (rd_data !== 64'h1) begin nFail++; $display("FAIL busy_clear got %h exp 1", rd_data); end
      op(1'b0, 1'b0, 16'h0, 9'h0, 64'h0, 4'b0001);
   endtask

   task automatic test_zero_size();
      doWrite(16'h0044, 64'h0);
      doWrite(16'h0046, 64'h1);
      nTests++;
      if (ch_start !== 4'b0000) begin nFail++; $display("FAIL zero_start got %b exp 0000", ch_start); end
      doRead(16'h0048, 9'h09);
      nTests++;
      if (rd_data !== 64'h1_0000_0002) begin nFail++; $display("FAIL zero_status got %h exp 100000002", rd_data); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] addrs [3];
      logic [63:0] exps [3];
      addrs = '{16'h0010, 16'h0000, 16'h0004};
      exps  = '{64'd4, 64'h1000_0100_0000_0000, UUID[127:64]};
      for (int i = 0; i < 3; i++) begin
         doRead(addrs[i], 9'(i + 16'h101));
         nTests++;
         if (rd_valid !== 1'b1 || rd_tid !== 9'(i + 16'h101) || rd_data !== exps[i]) begin
            nFail++; $display("FAIL b2b[%0d] got v=%b tid=%h d=%h exp d=%h", i, rd_valid, rd_tid, rd_data, exps[i]);
         end
      end
   endtask

   task automatic test_odd_unmapped();
      doWrite(16'h0013, 64'hFFFF);
      doRead(16'h0013, 9'h0B);
      nTests++;
      if (rd_valid !== 1'b1 || rd_data !== 64'h0) begin
         nFail++; $display("FAIL odd_read got v=%b d=%h exp v=1 d=0", rd_valid, rd_data);
      end
      doRead(16'h00F0, 9'h0C);
      nTests++;
      if (rd_valid !== 1'b1 || rd_data !== 64'h0) begin
         nFail++; $display("FAIL unmapped_read got v=%b d=%h exp v=1 d=0", rd_valid, rd_data);
      end
      op(1'b1, 1'b1, 16'h0012, 9'h0D, 64'h5, '0);
      nTests++;
      if (rd_data !== 64'h0) begin nFail++; $display("FAIL rw_same_cycle got %h exp 0", rd_data); end
      doRead(16'h0012, 9'h0E);
      nTests++;
      if (rd_data !== 64'h5) begin nFail++; $display("FAIL scratch_after got %h exp 5", rd_data); end
   endtask

   task automatic test_done_start_same();
      doWrite(16'h0054, 64'h40);
      doWrite(16'h0056, 64'h1);
      nTests++;
      if (ch_start !== 4'b1000) begin nFail++; $display("FAIL ch3_first_start got %b exp 1000", ch_start); end
      op(1'b1, 1'b0, 16'h0056, 9'h0, 64'h1, 4'b1000);
      nTests++;
      if (ch_start !== 4'b1000) begin nFail++; $display("FAIL ch3_restart got %b exp 1000", ch_start); end
      doRead(16'h0058, 9'h0F);
      nTests++;
      if (rd_data !== 64'h1_0000_0003) begin nFail++; $display("FAIL ch3_status got %h exp 100000003", rd_data); end
      doRead(16'h0058, 9'h10);
      reset = 1'b1;
      #1;
      nTests++;
      if (rd_valid !== 1'b0 || ch_start !== '0) begin
         nFail++; $display("FAIL async_reset got rd_valid=%b start=%b exp 0", rd_valid, ch_start);
      end
      @(negedge clk);
      reset = 1'b0;
      mReset();
      for (int c = 0; c < NCH; c++) begin
         doRead(16'(32 + 16 * c + 8), 9'h11);
         nTests++;
         if (rd_data !== 64'h0) begin nFail++; $display("FAIL post_reset_status[%0d] got %h exp 0", c, rd_data); end
      end
   endtask

   task automatic test_random();
      logic [15:0]       a;
      logic [63:0]       wd;
      logic [NCH*42-1:0] eSrc, eDst;
      logic [NCH*32-1:0] eSize;
      for (int it = 0; it < 600; it++) begin
         case ($urandom_range(0, 7))
            0:       a = 16'($urandom_range(0, 255));
            1:       a = 16'h0012;
            default: a = 16'(32 + 16 * $urandom_range(0, NCH - 1) + 2 * $urandom_range(0, 4));
         endcase
         if (a[3:0] == 4'h4)      wd = 64'($urandom_range(0, 3) * 64 + $urandom_range(0, 63));
         else if (a[3:0] == 4'h6) wd = 64'($urandom_range(0, 3));
         else                     wd = {$urandom, $urandom};
         op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 9'($urandom),
            wd, ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0);
         for (int i = 0; i < NCH; i++) begin
            eSrc[i*42 +: 42] = mSrc[i];
            eDst[i*42 +: 42] = mDst[i];
            eSize[i*32 +: 32] = mSize[i];
         end
         nTests++;
         if (rd_valid !== expValid || (expValid && (rd_data !== expRd || rd_tid !== expTid))) begin
            nFail++; $display("FAIL rand_read[%0d] addr=%h got v=%b d=%h tid=%h exp v=%b d=%h tid=%h",
                              it, a, rd_valid, rd_data, rd_tid, expValid, expRd, expTid);
         end
         nTests++;
         if (ch_start !== expStart) begin
            nFail++; $display("FAIL rand_start[%0d] got %b exp %b", it, ch_start, expStart);
         end
         nTests++;
         if (ch_src_addr !== eSrc || ch_dst_addr !== eDst || ch_size_cl !== eSize) begin
            nFail++; $display("FAIL rand_desc[%0d] got size=%h exp size=%h", it, ch_size_cl, eSize);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      mmio_wr_valid = 1'b0; mmio_rd_valid = 1'b0; mmio_addr = '0;
      mmio_tid = '0; mmio_wdata = '0; ch_done = '0;
      mReset();
      repeat (2) @(negedge clk);
      test_reset();
      test_header();
      test_ch1();
      test_busy_err();
      test_zero_size();
      test_back_to_back();
      test_odd_unmapped();
      test_done_start_same();
      test_random();
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule

// File: doc/dma_csr_bank.md
# dma_csr_bank

Multi-channel MMIO control/status register bank for CCI-P copy engines, generalising the single-channel AFU CSR decode to `NUM_CH` independent copy channels. Decodes MMIO writes and reads, serves the AFU DFH/UUID header, holds per-channel source, destination and size descriptors, and issues start pulses to the engines. Tracks per-channel busy, done, error and completion count. Sits between the `ccip_std_afu` top-level MMIO path and an array of DMA engines.

## Interface

- `NUM_CH`, 4: number of copy channels, 1..8.
- `SIZE_W`, 32: width of the per-channel cache-line count.
- `AFU_ID`, 128'h0: UUID returned at 0x0002/0x0004.
- `clk`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `mmio_wr_valid`  in  1  MMIO write strobe (c0 mmioWrValid).
- `mmio_rd_valid`  in  1  MMIO read strobe (c0 mmioRdValid).
- `mmio_addr`  in  16  dword address from the MMIO request header.
- `mmio_tid`  in  9  read transaction ID.
- `mmio_wdata`  in  64  write data.
- `rd_valid`  out  1  read response valid (c2 mmioRdValid).
- `rd_tid`  out  9  echoed TID.
- `rd_data`  out  64  read response data.
- `ch_src_addr`  out  NUM_CH*42  per-channel source cache-line address; channel i occupies [42i+41:42i].
- `ch_dst_addr`  out  NUM_CH*42  per-channel destination cache-line address.
- `ch_size_cl`  out  NUM_CH*SIZE_W  per-channel length in cache lines.
- `ch_start`  out  NUM_CH  one-cycle start pulse per channel.
- `ch_done`  in  NUM_CH  one-cycle completion pulse from each engine.

## Operation

- Address map, dword addresses; 64-bit CSRs sit at even addresses only. Odd-address writes are ignored; odd-address reads return 0.
- 0x0000 DFH: {4'b0001, 8'b0, 4'b0, 7'b0, 1'b1, 24'b0, 4'b0, 12'b0}. Read-only.
- 0x0002/0x0004: AFU_ID[63:0] and AFU_ID[127:64]. Read-only.
- 0x0010: NUM_CH, read-only.
- 0x0012: scratch register, 64-bit, read/write.
- Channel c has base B = 0x0020 + 0x10·c:
  - B+0 SRC: read/write, stores wdata[41:0].
  - B+2 DST: read/write, stores wdata[41:0].
  - B+4 SIZE: write stores wdata[SIZE_W+5:6] (bytes >> 6, truncated); read returns the stored count << 6.
  - B+6 CTRL: write-only, reads 0. Bit0 = start; bit1 = clear done/err.
  - B+8 STATUS: read-only. Bit0 busy, bit1 done (sticky), bit2 err (sticky), bits [63:32] completion count.
- Any other address: writes are ignored, reads return 0.
- Writes to SRC/DST/SIZE while the channel is busy are dropped and set err.
- Start handling:
  - Start while idle with size ≠ 0: busy←1 and one `ch_start` pulse.
  - Start while idle with size = 0: no pulse; done←1 and count increments, in the same cycle.
  - Start while busy: ignored; err←1.
- Per-channel state is IDLE → BUSY on accepted start, and BUSY → IDLE on `ch_done`.
- `ch_done` while busy: busy←0, done←1, count+1. The count wraps from 2^32−1 to 0.
- `ch_done` while idle is ignored.
- `ch_done` and a CTRL start in the same cycle: done is processed first, then the start is evaluated against busy=0. Net result: busy stays 1, done←1, count+1, `ch_start` pulses.
- CTRL with bit0 and bit1 both set: clear is applied first, then start.
- Simultaneous `mmio_wr_valid` and `mmio_rd_valid`: both are serviced; the read returns the pre-write value.

## Timing

- Reset values: all registers, busy/done/err/count, `ch_start`, `rd_valid`, `rd_tid` and `rd_data` are 0. Descriptor outputs are 0.
- Reset asserted mid-copy clears busy with no further pulses; engines reset independently.
- Write latency: a register write is visible on its output, and on a read, the cycle after the `mmio_wr_valid` edge.
- `ch_start` is registered: it is high exactly one cycle, in the cycle after the CTRL write edge. Descriptor outputs are stable from that cycle until busy drops.
- Read latency: exactly 1 cycle. `rd_valid` is high exactly one cycle, the cycle after `mmio_rd_valid`, with `rd_tid` = captured `mmio_tid`. `rd_valid` is 0 otherwise.
- Back-to-back reads on consecutive cycles give back-to-back responses, in order.
- STATUS reflects `ch_done` one cycle after the done pulse.

## Test plan

- Reset, then read 0x0000, 0x0002, 0x0004, 0x0010 with tid 0x1A → DFH 0x1000_0100_0000_0000, both UUID halves, then 4; each `rd_valid` one cycle after its request, tid 0x1A.
- Ch1: write SRC=0x100 at 0x0030, DST=0x200, SIZE=4096 at 0x0034, then CTRL=1 at 0x0036 → `ch_start[1]` one pulse; `ch_size_cl` slice = 64; STATUS at 0x0038 = 0x1. Pulse `ch_done[1]` → STATUS = 0x1_0000_0002.
- Ch0 busy: write SRC, then CTRL=1 → SRC unchanged, no pulse, STATUS bit2 = 1. Then CTRL=2 → err and done clear.
- Ch2: SIZE=0 then CTRL=1 → no `ch_start[2]`; next-cycle STATUS = 0x1_0000_0002.
- Ch3 busy: `ch_done[3]` in the same cycle as a CTRL=1 write → `ch_start[3]` pulses, busy=1, count=1. Also assert reset mid-busy → all STATUS = 0 and `rd_valid` = 0.
- Read of 0x0013 and of 0x00F0 → data 0, `rd_valid` still asserted. Same-cycle write 0x5 and read at 0x0012 (scratch 0) → returns 0; next read returns 5.
